sar_logic: RTL and testbench
============================

SAR_LOGIC -- requirements
Module: sar_logic

Interface
REQ-001 The block SHALL have one clock, `clock`, and one reset, `resetb`; reset SHALL be asynchronous and active-low.
REQ-002 Parameter NBITS, default 6, SHALL set the converter resolution in bits.
REQ-003 Port `clock`, input, 1 bit: rising-edge system clock.
REQ-004 Port `resetb`, input, 1 bit: asynchronous active-low reset.
REQ-005 Port `start`, input, 1 bit: conversion request, sampled on `clock`.
REQ-006 Port `comp`, input, 1 bit: comparator decision; 1 means the trial bit is kept.
REQ-007 Port `sample`, output, 1 bit: sampling switch enable.
REQ-008 Port `dac_rst`, output, 1 bit: DAC top-plate precharge enable.
REQ-009 Port `dac_ctrl`, output, 2*NBITS bits: switch pair for bit k is {p,n} = dac_ctrl[2k+1:2k].
REQ-010 Port `dout`, output, NBITS bits: last conversion result.
REQ-011 Port `eoc`, output, 1 bit: one-cycle end-of-conversion pulse.
REQ-012 Port `busy`, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, PRECHARGE, SAMPLE, CONV and DONE.
REQ-014 IDLE SHALL drive sample=0, dac_rst=0 and every pair=01 (6-bit: 0x555); it SHALL move to PRECHARGE on the first edge with start=1.
REQ-015 PRECHARGE SHALL last one cycle with sample=1, dac_rst=1 and every pair=10 (0xAAA).
REQ-016 SAMPLE SHALL last one cycle with sample=1, dac_rst=0 and every pair=01 (0x555).
REQ-017 CONV SHALL last NBITS cycles with sample=0 and dac_rst=0, and SHALL test bits from MSB to LSB, one bit per cycle.
REQ-018 In each CONV cycle:
- the bit under test SHALL be 10 (trial);
- bits already decided SHALL show 10 if kept and 01 if dropped;
- bits not yet tested SHALL be 01.
REQ-019 The `comp` value at the rising edge ending a CONV cycle SHALL decide that bit: comp=1 keeps 10 and sets the result bit to 1; comp=0 reverts the pair to 01 and sets the result bit to 0.
REQ-020 DONE SHALL last one cycle with eoc=1 and dout loaded from the decided bits, then return to IDLE.
REQ-021 Latency from start to eoc SHALL be NBITS+3 cycles (9 for NBITS=6).
REQ-022 `start` SHALL be ignored while busy=1.
REQ-023 `dout` SHALL hold its value until the next DONE.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 On resetb=0 the block SHALL immediately enter IDLE with sample=0, dac_rst=0, dac_ctrl=all pairs 01, dout=0, eoc=0 and busy=0, including when reset is asserted mid-conversion.

Configuration
REQ-026 With macro SAR_LOGIC_CONT_EN defined, DONE SHALL go directly to PRECHARGE (free-running conversion after the first start).
REQ-027 Without SAR_LOGIC_CONT_EN, DONE SHALL go to IDLE (single-shot conversion).

Structure
REQ-028 Package sar_logic_pkg SHALL hold the FSM state enum and the pair encodings PAIR_TRIAL=2'b10 and PAIR_ZERO=2'b01.
REQ-029 The design SHALL have no sub-modules; the successive-approximation register and the FSM SHALL be implemented in sar_logic.

Verification
REQ-030 Scenario: comp=0 always, start pulse -> {sample,dac_rst,dac_ctrl} SHALL step through:
- (1,1,AAA), (1,0,555);
- (0,0,955), (0,0,655), (0,0,595), (0,0,565), (0,0,559), (0,0,556);
- then eoc=1 with dout=0x00.
REQ-031 Scenario: comp=1 always -> CONV SHALL show 955, A55, A95, AA5, AA9, AAA, then dout=0x3F.
REQ-032 Scenario: comp=1,0,1,0,1,0 (MSB first) -> dout SHALL be 0x2A and eoc SHALL come 9 cycles after start.
REQ-033 Scenario: resetb pulsed low during the third CONV cycle -> outputs SHALL show IDLE values at once, and a following start SHALL give a full, correct conversion.
REQ-034 Scenario: start held high during a conversion -> no restart; with SAR_LOGIC_CONT_EN, PRECHARGE SHALL follow DONE with start=0.

Source files
------------

// File: rtl/sar_logic_pkg.sv
// Shared definitions for the SAR converter control logic: FSM states and
// the DAC switch-pair encodings.
package sar_logic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_SAMPLE    = 3'd2,
        ST_CONV      = 3'd3,
        ST_DONE      = 3'd4
    } sar_state_e;

    localparam logic [1:0] PAIR_TRIAL = 2'b10;
    localparam logic [1:0] PAIR_ZERO  = 2'b01;

endpackage

// File: rtl/sar_logic.sv
// Successive-approximation register and sequencing FSM for an NBITS SAR ADC.
// Define SAR_LOGIC_CONT_EN for free-running conversion after the first start.
module sar_logic
    import sar_logic_pkg::*;
#(
    parameter int NBITS = 6
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 start,
    input  logic                 comp,
    output logic                 sample,
    output logic                 dac_rst,
    output logic [2*NBITS-1:0]   dac_ctrl,
    output logic [NBITS-1:0]     dout,
    output logic                 eoc,
    output logic                 busy
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [2*NBITS-1:0] IDLE_PAIRS = {NBITS{PAIR_ZERO}};

    sar_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NBITS-1:0]     res_q, res_d;
    logic [NBITS-1:0]     dout_q, dout_d;
    logic [NBITS-1:0]     kept, trial;
    logic                 sample_q, sample_d;
    logic                 dac_rst_q, dac_rst_d;
    logic                 eoc_q, eoc_d;
    logic                 busy_q, busy_d;
    logic [2*NBITS-1:0]   dac_ctrl_q, dac_ctrl_d;

    // A pair shows TRIAL when its bit is set in the code, ZERO otherwise.
    function automatic logic [2*NBITS-1:0] conv_pairs(input logic [NBITS-1:0] code);
        logic [2*NBITS-1:0] pairs;
        for (int j = 0; j < NBITS; j++) begin
            pairs[2*j +: 2] = code[j] ? PAIR_TRIAL : PAIR_ZERO;
        end
        return pairs;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_PRECHARGE;
            end
            ST_PRECHARGE: state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                state_d = ST_CONV;
                cnt_d   = CW'(NBITS - 1);
                res_d   = '0;
            end
            ST_CONV: begin
                res_d[cnt_q] = comp;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    dout_d  = res_d;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DONE: begin
`ifdef SAR_LOGIC_CONT_EN
                state_d = ST_PRECHARGE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave the flops aligned with it.
    always_comb begin
        kept  = '0;
        trial = '0;
        case (state_d)
            ST_PRECHARGE: kept = '1;
            ST_CONV: begin
                kept  = res_d;
                trial = NBITS'(1) << cnt_d;
            end
            ST_DONE: kept = res_d;
            default: kept = '0;
        endcase
        sample_d   = (state_d == ST_PRECHARGE) || (state_d == ST_SAMPLE);
        dac_rst_d  = (state_d == ST_PRECHARGE);
        eoc_d      = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
        dac_ctrl_d = conv_pairs(kept | trial);
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ST_IDLE;
            sample_q   <= 1'b0;
            dac_rst_q  <= 1'b0;
            eoc_q      <= 1'b0;
            busy_q     <= 1'b0;
            dac_ctrl_q <= IDLE_PAIRS;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            dac_rst_q  <= dac_rst_d;
            eoc_q      <= eoc_d;
            busy_q     <= busy_d;
            dac_ctrl_q <= dac_ctrl_d;
            dout_q     <= dout_d;
        end
    end

    // Working register and bit pointer are reloaded on every SAMPLE, so they need no reset.
    always_ff @(posedge clock) begin
        cnt_q <= cnt_d;
        res_q <= res_d;
    end

    assign sample   = sample_q;
    assign dac_rst  = dac_rst_q;
    assign dac_ctrl = dac_ctrl_q;
    assign dout     = dout_q;
    assign eoc      = eoc_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_sar_logic.sv
// Bench for sar_logic: an ideal comparator against a hidden input level drives
// comp, and each cycle is checked against a binary-search model of the conversion.
module tb_sar_logic;

    localparam int NB = 6;

    logic              clock;
    logic              resetb;
    logic              start;
    logic              comp;
    logic              sample;
    logic              dac_rst;
    logic [2*NB-1:0]   dac_ctrl;
    logic [NB-1:0]     dout;
    logic              eoc;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    sar_logic #(.NBITS(NB)) dut (
        .clock    (clock),
        .resetb   (resetb),
        .start    (start),
        .comp     (comp),
        .sample   (sample),
        .dac_rst  (dac_rst),
        .dac_ctrl (dac_ctrl),
        .dout     (dout),
        .eoc      (eoc),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // DAC switch pattern for a given trial code: set bit -> 10, clear bit -> 01.
    function automatic logic [2*NB-1:0] enc(input logic [NB-1:0] code);
        logic [2*NB-1:0] r;
        for (int j = 0; j < NB; j++) r[2*j +: 2] = code[j] ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sample"}, 64'(sample), 64'd0);
        check({tag, "_dacrst"}, 64'(dac_rst), 64'd0);
        check({tag, "_ctrl"}, 64'(dac_ctrl), 64'(enc('0)));
        check({tag, "_eoc"}, 64'(eoc), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // One full conversion of input level vin; hold keeps start high throughout.
    task automatic do_conv(input int vin, input bit hold);
        logic [NB-1:0] code;
        logic [NB-1:0] trial;
        logic [NB-1:0] ones;
        ones  = '1;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        check("pre_sample", 64'(sample), 64'd1);
        check("pre_dacrst", 64'(dac_rst), 64'd1);
        check("pre_ctrl", 64'(dac_ctrl), 64'(enc(ones)));
        check("pre_busy", 64'(busy), 64'd1);
        step();
        check("smp_sample", 64'(sample), 64'd1);
        check("smp_dacrst", 64'(dac_rst), 64'd0);
        check("smp_ctrl", 64'(dac_ctrl), 64'(enc('0)));
        code = '0;
        for (int k = NB - 1; k >= 0; k--) begin
            step();
            trial = code | (NB'(1) << k);
            check("conv_sample", 64'(sample), 64'd0);
            check("conv_dacrst", 64'(dac_rst), 64'd0);
            check("conv_ctrl", 64'(dac_ctrl), 64'(enc(trial)));
            check("conv_eoc", 64'(eoc), 64'd0);
            check("conv_busy", 64'(busy), 64'd1);
            comp = (vin >= int'(trial));
            if (comp) code = trial;
        end
        step();
        check("done_eoc", 64'(eoc), 64'd1);
        check("done_dout", 64'(dout), 64'(vin));
        check("done_busy", 64'(busy), 64'd1);
        start = 1'b0;
        comp  = 1'b0;
        step();
        check_idle("after");
        check("hold_dout", 64'(dout), 64'(vin));
    endtask

    initial begin
        int v;
        resetb = 1'b0;
        start  = 1'b0;
        comp   = 1'b0;
        step();
        step();
        check_idle("rst");
        check("rst_dout", 64'(dout), 64'd0);
        resetb = 1'b1;
        step();
        check_idle("idle");

        do_conv(0, 1'b0);
        do_conv(63, 1'b0);
        do_conv(42, 1'b0);
        do_conv(21, 1'b1);

        // Reset in the third CONV cycle, then a clean conversion.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            comp = 1'b1;
            step();
        end
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_ctrl", 64'(dac_ctrl), 64'(enc(6'b111000)));
        resetb = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst_dout", 64'(dout), 64'd0);
        step();
        resetb = 1'b1;
        comp   = 1'b0;
        step();
        check_idle("postrst");
        do_conv(37, 1'b0);

        for (int n = 0; n < 6; n++) begin
            v = int'($urandom_range(0, 63));
            do_conv(v, n[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
